// File: rtl/multitrig_pkg.sv
// Shared types and sizing helpers for the multitrig coincidence/sum trigger.
package multitrig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam int unsigned CH_W = 16;

    // Sum width that holds NCH sign-extended channels without overflow.
    function automatic int unsigned sum_width(input int unsigned nch);
        return CH_W + $clog2(nch);
    endfunction

endpackage

// File: rtl/multitrig_sum.sv
// Two-stage trigger datapath: per-channel threshold hits and channel sum,
// then majority count and sum comparisons producing registered arm/rel.
module multitrig_sum
    import multitrig_pkg::*;
#(
    parameter int unsigned NCH   = 4,
    parameter int unsigned ABITS = 12,
    parameter int unsigned MBITS = $clog2(NCH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [CH_W*NCH-1:0]   dpdata_i,
    input  logic [ABITS-1:0]      ithr_i,
    input  logic [ABITS-1:0]      sthr_i,
    input  logic [MBITS-1:0]      mcnt_i,
    output logic                  arm_o,
    output logic                  rel_o
);

    localparam int unsigned SW = sum_width(NCH);

    logic signed [CH_W-1:0] ch [NCH];
    logic        [NCH-1:0]  hit_d, hit_q;
    logic signed [SW-1:0]   sum_d, sum_q;
    logic signed [SW-1:0]   ithr_s, sthr_s, shalf_s;
    logic        [MBITS-1:0] nhit, need;
    logic                   arm_d, arm_q, rel_d, rel_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign ch[i] = dpdata_i[CH_W*i +: CH_W];
    end

    assign ithr_s  = SW'($signed({1'b0, ithr_i}));
    assign sthr_s  = SW'($signed({1'b0, sthr_i}));
    assign shalf_s = SW'($signed({1'b0, sthr_i[ABITS-1:1]}));

    // Stage 1: individual hits and full-width signed sum.
    always_comb begin
        hit_d = '0;
        sum_d = '0;
        for (int i = 0; i < NCH; i++) begin
            hit_d[i] = SW'(ch[i]) > ithr_s;
            sum_d    = sum_d + SW'(ch[i]);
        end
    end

    // Stage 2: majority (mcnt of 0 counts as 1) and hysteresis compares.
    always_comb begin
        nhit = '0;
        for (int i = 0; i < NCH; i++) begin
            nhit = nhit + MBITS'(hit_q[i]);
        end
        need  = (mcnt_i == '0) ? MBITS'(1) : mcnt_i;
        arm_d = (nhit >= need) && (sum_q > sthr_s);
        rel_d = (sum_q <= shalf_s);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_q <= '0;
            sum_q <= '0;
            arm_q <= 1'b0;
            rel_q <= 1'b0;
        end else begin
            hit_q <= hit_d;
            sum_q <= sum_d;
            arm_q <= arm_d;
            rel_q <= rel_d;
        end
    end

    assign arm_o = arm_q;
    assign rel_o = rel_q;

endmodule

// File: rtl/multitrig.sv
// N-channel coincidence/sum trigger: datapath sub-module plus trigger FSM,
// dead-time counter and wrapping trigger counter.
module multitrig
    import multitrig_pkg::*;
#(
    parameter int unsigned NCH    = 4,
    parameter int unsigned ABITS  = 12,
    parameter int unsigned DTBITS = 8,
    parameter int unsigned CBITS  = 16
) (
    input  logic                       ADCCLK,
    input  logic                       RST,
    input  logic [CH_W*NCH-1:0]        dpdata,
    input  logic [ABITS-1:0]           ithr,
    input  logic [ABITS-1:0]           sthr,
    input  logic [$clog2(NCH+1)-1:0]   mcnt,
    input  logic [DTBITS-1:0]          dtime,
    input  logic                       raw,
    input  logic                       dtmask,
    input  logic                       cntclr,
    output logic                       ddiscr,
    output logic                       dtrig,
    output logic                       busy,
    output logic [CBITS-1:0]           trigcnt
);

    state_e              state_q;
    logic [DTBITS-1:0]   dtcnt_q;
    logic [CBITS-1:0]    trigcnt_q;
    logic [CBITS-1:0]    cnt_base;
    logic                ddiscr_q, dtrig_q, busy_q;
    logic                arm, rel, inhibit;

    multitrig_sum #(
        .NCH   (NCH),
        .ABITS (ABITS)
    ) u_sum (
        .clk_i    (ADCCLK),
        .rst_i    (RST),
        .dpdata_i (dpdata),
        .ithr_i   (ithr),
        .sthr_i   (sthr),
        .mcnt_i   (mcnt),
        .arm_o    (arm),
        .rel_o    (rel)
    );

    assign inhibit  = raw | dtmask;
    // A clear in the same cycle as a trigger counts from zero.
    assign cnt_base = cntclr ? '0 : trigcnt_q;

    always_ff @(posedge ADCCLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            dtcnt_q   <= '0;
            trigcnt_q <= '0;
            ddiscr_q  <= 1'b0;
            dtrig_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            dtrig_q <= 1'b0;
            if (cntclr) begin
                trigcnt_q <= '0;
            end
            if (inhibit) begin
                state_q  <= ST_IDLE;
                dtcnt_q  <= '0;
                ddiscr_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (arm) begin
                            state_q   <= ST_FIRE;
                            ddiscr_q  <= 1'b1;
                            dtrig_q   <= 1'b1;
                            busy_q    <= 1'b1;
                            trigcnt_q <= cnt_base + CBITS'(1);
                        end
                    end
                    ST_FIRE: begin
                        if (rel) begin
                            ddiscr_q <= 1'b0;
                            if (dtime == '0) begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= ST_HOLD;
                                dtcnt_q <= dtime;
                            end
                        end
                    end
                    ST_HOLD: begin
                        // Dead time: arm is ignored until the count runs out.
                        if (dtcnt_q <= DTBITS'(1)) begin
                            state_q <= ST_IDLE;
                            dtcnt_q <= '0;
                            busy_q  <= 1'b0;
                        end else begin
                            dtcnt_q <= dtcnt_q - DTBITS'(1);
                        end
                    end
                    default: begin
                        state_q  <= ST_IDLE;
                        dtcnt_q  <= '0;
                        ddiscr_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ddiscr  = ddiscr_q;
    assign dtrig   = dtrig_q;
    assign busy    = busy_q;
    assign trigcnt = trigcnt_q;

endmodule

// File: tb/tb_multitrig.sv
// Bench for multitrig: directed scenarios with literal expectations, then
// randomized stimulus checked every cycle against a behavioural model.
module tb_multitrig;

    logic        ADCCLK;
    logic        RST;
    logic [63:0] dpdata;
    logic [11:0] ithr, sthr;
    logic [2:0]  mcnt;
    logic [7:0]  dtime;
    logic        raw, dtmask, cntclr;
    logic        ddiscr, dtrig, busy;
    logic [15:0] trigcnt;
    logic        ddiscr_w, dtrig_w, busy_w;
    logic [3:0]  trigcnt_w;

    int n_checks = 0;
    int n_pass   = 0;

    multitrig #(.NCH(4), .ABITS(12), .DTBITS(8), .CBITS(16)) dut (
        .ADCCLK(ADCCLK), .RST(RST), .dpdata(dpdata), .ithr(ithr), .sthr(sthr),
        .mcnt(mcnt), .dtime(dtime), .raw(raw), .dtmask(dtmask), .cntclr(cntclr),
        .ddiscr(ddiscr), .dtrig(dtrig), .busy(busy), .trigcnt(trigcnt)
    );

    // Narrow-counter copy so counter wrap is exercised within a short run.
    multitrig #(.NCH(4), .ABITS(12), .DTBITS(8), .CBITS(4)) dut_w (
        .ADCCLK(ADCCLK), .RST(RST), .dpdata(dpdata), .ithr(ithr), .sthr(sthr),
        .mcnt(mcnt), .dtime(dtime), .raw(raw), .dtmask(dtmask), .cntclr(cntclr),
        .ddiscr(ddiscr_w), .dtrig(dtrig_w), .busy(busy_w), .trigcnt(trigcnt_w)
    );

    initial ADCCLK = 1'b0;
    always #5 ADCCLK = ~ADCCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int chan(input int i);
        logic signed [15:0] w;
        w = dpdata[16*i +: 16];
        return int'(w);
    endfunction

    // Behavioural model: hit count and sum one edge after the inputs,
    // arm/release one edge later, trigger state as "firing" plus remaining dead cycles.
    int m_hits1, m_sum1, m_dead, m_cnt;
    bit m_arm, m_rel, m_fire, m_trig;

    always @(posedge ADCCLK) begin
        int need, nh, s, v;
        bit a, r;
        if (RST) begin
            m_hits1 = 0; m_sum1 = 0; m_arm = 0; m_rel = 0;
            m_fire = 0; m_dead = 0; m_trig = 0; m_cnt = 0;
        end else begin
            need = (mcnt == 3'd0) ? 1 : int'(mcnt);
            a = (m_hits1 >= need) && (m_sum1 > int'(sthr));
            r = m_sum1 <= int'(sthr) / 2;
            nh = 0;
            s = 0;
            for (int i = 0; i < 4; i++) begin
                v = chan(i);
                s += v;
                if (v > int'(ithr)) nh++;
            end
            if (cntclr) m_cnt = 0;
            m_trig = 0;
            if (raw || dtmask) begin
                m_fire = 0;
                m_dead = 0;
            end else if (m_fire) begin
                if (m_rel) begin
                    m_fire = 0;
                    m_dead = int'(dtime);
                end
            end else if (m_dead > 0) begin
                m_dead--;
            end else if (m_arm) begin
                m_fire = 1;
                m_trig = 1;
                m_cnt  = (m_cnt + 1) % 65536;
            end
            m_hits1 = nh;
            m_sum1  = s;
            m_arm   = a;
            m_rel   = r;
        end
    end

    always @(posedge ADCCLK) begin
        #1;
        check("ddiscr", 32'(ddiscr), 32'(m_fire));
        check("dtrig", 32'(dtrig), 32'(m_trig));
        check("busy", 32'(busy), 32'(m_fire || (m_dead > 0)));
        check("trigcnt", 32'(trigcnt), 32'(m_cnt));
        check("narrow_flags", 32'({ddiscr_w, dtrig_w, busy_w}),
              32'({m_fire, m_trig, (m_fire || (m_dead > 0))}));
        check("narrow_trigcnt", 32'(trigcnt_w), 32'(m_cnt % 16));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge ADCCLK);
    endtask

    task automatic set_ch(input int a, input int b, input int c, input int d);
        dpdata = {16'(d), 16'(c), 16'(b), 16'(a)};
    endtask

    initial begin
        RST = 1'b1; dpdata = '0; ithr = 12'd100; sthr = 12'd300; mcnt = 3'd2;
        dtime = 8'd5; raw = 1'b0; dtmask = 1'b0; cntclr = 1'b0;
        tick(2);
        check("rst_outs", 32'({ddiscr, dtrig, busy}), 32'd0);
        check("rst_cnt", 32'(trigcnt), 32'd0);
        RST = 1'b0;
        tick(2);

        set_ch(150, 160, 0, 0);
        tick(2);
        check("latency_early", 32'(ddiscr), 32'd0);
        tick(1);
        check("first_ddiscr", 32'(ddiscr), 32'd1);
        check("first_dtrig", 32'(dtrig), 32'd1);
        check("first_cnt", 32'(trigcnt), 32'd1);
        tick(1);
        check("strobe_len", 32'({ddiscr, dtrig}), 32'b10);

        set_ch(200, 0, 0, 0);
        tick(4);
        check("hyst_200", 32'(ddiscr), 32'd1);
        set_ch(150, 0, 0, 0);
        tick(3);
        check("rel_150", 32'(ddiscr), 32'd0);
        set_ch(150, 160, 0, 0);
        for (int k = 0; k < 5; k++) begin
            check("dead_busy", 32'({busy, dtrig}), 32'b10);
            tick(1);
        end
        check("dead_end", 32'({busy, dtrig}), 32'b00);
        tick(1);
        check("retrig", 32'(dtrig), 32'd1);
        check("retrig_cnt", 32'(trigcnt), 32'd2);

        set_ch(0, 0, 0, 0);
        tick(12);
        set_ch(150, 0, 0, 0);
        tick(4);
        check("low_sum", 32'({ddiscr, 16'(trigcnt)}), 32'd2);
        set_ch(400, 0, 0, 0);
        tick(4);
        check("one_hit", 32'({busy, 16'(trigcnt)}), 32'd2);

        dtime = 8'd0;
        set_ch(150, 160, 0, 0);
        tick(3);
        check("dt0_fire", 32'({dtrig, 16'(trigcnt)}), 32'h10003);
        set_ch(0, 0, 0, 0);
        tick(1);
        set_ch(150, 160, 0, 0);
        tick(2);
        check("dt0_idle", 32'({ddiscr, busy}), 32'd0);
        tick(1);
        check("dt0_rearm", 32'({dtrig, 16'(trigcnt)}), 32'h10004);

        dtime = 8'd5;
        set_ch(-32768, -32768, -32768, -32768);
        tick(12);
        check("neg_full", 32'({ddiscr, busy, 16'(trigcnt)}), 32'd4);
        sthr = 12'd4095;
        set_ch(32767, 32767, 32767, 32767);
        tick(3);
        check("pos_full", 32'({dtrig, 16'(trigcnt)}), 32'h10005);

        tick(1);
        check("inh_pre", 32'(ddiscr), 32'd1);
        dtmask = 1'b1;
        tick(1);
        check("inh_outs", 32'({ddiscr, busy}), 32'd0);
        tick(2);
        check("inh_cnt", 32'({dtrig, 16'(trigcnt)}), 32'd5);
        dtmask = 1'b0;
        tick(1);
        check("inh_release", 32'({dtrig, 16'(trigcnt)}), 32'h10006);

        set_ch(0, 0, 0, 0);
        tick(12);
        set_ch(32767, 32767, 32767, 32767);
        tick(2);
        cntclr = 1'b1;
        tick(1);
        cntclr = 1'b0;
        check("clr_with_trig", 32'({dtrig, 16'(trigcnt)}), 32'h10001);

        tick(1);
        RST = 1'b1;
        #1;
        check("async_rst", 32'({ddiscr, busy, 16'(trigcnt)}), 32'd0);
        tick(1);
        RST = 1'b0;
        tick(4);
        check("post_rst_fire", 32'(trigcnt), 32'd1);
        for (int k = 0; k < 15; k++) begin
            dtmask = 1'b1;
            tick(1);
            dtmask = 1'b0;
            tick(1);
        end
        check("cnt16", 32'(trigcnt), 32'd16);
        check("narrow_wrap", 32'(trigcnt_w), 32'd0);

        ithr = 12'd100; sthr = 12'd300;
        for (int c = 0; c < 4000; c++) begin
            @(negedge ADCCLK);
            RST    = ($urandom_range(0, 999) == 0);
            raw    = ($urandom_range(0, 99) < 2);
            dtmask = ($urandom_range(0, 99) < 2);
            cntclr = !raw && !dtmask && ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < 4; i++) begin
                    int v;
                    if ($urandom_range(0, 9) == 0) v = int'($urandom_range(0, 65535));
                    else v = int'($urandom_range(0, 500)) - 100;
                    dpdata[16*i +: 16] = 16'(v);
                end
            end
            if ($urandom_range(0, 199) == 0) begin
                ithr  = 12'($urandom_range(0, 300));
                sthr  = 12'($urandom_range(0, 1200));
                mcnt  = 3'($urandom_range(0, 7));
                dtime = 8'($urandom_range(0, 7));
            end
        end
        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
